// File: rtl/bp_stream_byte_packer.sv
// Packs a little-endian byte stream into stream_data_width_p words behind a 2-entry
// output FIFO; partial words are dropped after an idle timeout and flagged sticky.
module bp_stream_byte_packer #(
    parameter int stream_data_width_p = 32,
    parameter int idle_timeout_p      = 1024,
    parameter int count_width_p       = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           byte_v_i,
    input  logic [7:0]                     byte_i,
    output logic                           byte_ready_o,
    output logic                           stream_v_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_ready_i,
    output logic [count_width_p-1:0]       words_o,
    output logic                           drop_o
);

    localparam int bytes_lp      = stream_data_width_p / 8;
    localparam int idx_width_lp  = $clog2(bytes_lp);
    localparam int idle_width_lp = (idle_timeout_p > 1) ? $clog2(idle_timeout_p) : 1;
    localparam logic [idx_width_lp-1:0]  idx_last_lp  = idx_width_lp'(bytes_lp - 1);
    localparam logic [idle_width_lp-1:0] idle_last_lp =
        idle_width_lp'((idle_timeout_p > 0) ? idle_timeout_p - 1 : 0);
    localparam logic timeout_en_lp = (idle_timeout_p > 0);

    logic [stream_data_width_p-1:0] asm_q, asm_d;
    logic [idx_width_lp-1:0]        idx_q, idx_d;
    logic [idle_width_lp-1:0]       idle_q, idle_d;
    logic                           drop_q, drop_d;
    logic [stream_data_width_p-1:0] buf_q [2];
    logic                           rd_ptr_q, wr_ptr_q;
    logic [1:0]                     cnt_q, cnt_d;
    logic [count_width_p-1:0]       words_q;

    logic                           last_byte, buf_full, accept, enq, deq;
    logic [stream_data_width_p-1:0] word_done;

    assign last_byte    = (idx_q == idx_last_lp);
    assign buf_full     = (cnt_q == 2'd2);
    // Ready depends only on registered state, so downstream ready never reaches the byte port.
    assign byte_ready_o = ~(last_byte & buf_full);
    assign accept       = byte_v_i & byte_ready_o;
    assign enq          = accept & last_byte;
    assign deq          = (cnt_q != 2'd0) & stream_ready_i;
    assign word_done    = {byte_i, asm_q[stream_data_width_p-9:0]};

    assign stream_v_o    = (cnt_q != 2'd0);
    assign stream_data_o = buf_q[rd_ptr_q];
    assign words_o       = words_q;
    assign drop_o        = drop_q;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        asm_d  = asm_q;
        idx_d  = idx_q;
        idle_d = idle_q;
        drop_d = drop_q;
        if (accept) begin
            asm_d[{idx_q, 3'b000} +: 8] = byte_i;
            idx_d  = last_byte ? '0 : idx_q + 1'b1;
            idle_d = '0;
        end else if (idx_q == '0) begin
            idle_d = '0;
        end else if (!byte_v_i && timeout_en_lp) begin
            // A byte arriving on the expiry cycle is accepted above, so it always beats the drop.
            if (idle_q == idle_last_lp) begin
                idx_d  = '0;
                idle_d = '0;
                drop_d = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q    <= '0;
            idle_q   <= '0;
            drop_q   <= 1'b0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            words_q  <= '0;
        end else begin
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            if (enq) wr_ptr_q <= ~wr_ptr_q;
            if (deq) begin
                rd_ptr_q <= ~rd_ptr_q;
                words_q  <= words_q + 1'b1;
            end
        end
    end

    // NOTE: data storage is not reset; occupancy and byte index alone decide what is valid.
    always_ff @(posedge clk_i) begin
        asm_q <= asm_d;
        if (enq) buf_q[wr_ptr_q] <= word_done;
    end

endmodule

// File: tb/tb_bp_stream_byte_packer.sv
// Scoreboard bench for bp_stream_byte_packer: a byte-list reference model predicts
// packed words and handshakes; a separate monitor pops and compares each consumed word.
module tb_bp_stream_byte_packer;

    localparam int W = 32;
    localparam int T = 16;
    localparam int C = 4;
    localparam int B = W / 8;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         byte_v_i = 1'b0;
    logic [7:0]   byte_i = 8'h00;
    logic         byte_ready_o;
    logic         stream_v_o;
    logic [W-1:0] stream_data_o;
    logic         stream_ready_i = 1'b0;
    logic [C-1:0] words_o;
    logic         drop_o;

    bp_stream_byte_packer #(
        .stream_data_width_p(W),
        .idle_timeout_p     (T),
        .count_width_p      (C)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .byte_v_i      (byte_v_i),
        .byte_i        (byte_i),
        .byte_ready_o  (byte_ready_o),
        .stream_v_o    (stream_v_o),
        .stream_data_o (stream_data_o),
        .stream_ready_i(stream_ready_i),
        .words_o       (words_o),
        .drop_o        (drop_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: bytes of the word in progress, words owed downstream.
    logic [7:0]   pend_q[$];
    logic [W-1:0] exp_q[$];
    int           idle_cnt  = 0;
    bit           exp_drop  = 0;
    int           exp_words = 0;
    int           words_made = 0;
    logic [W-1:0] last_word = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compares valid every cycle and pops one word per downstream consume.
    initial begin
        logic [W-1:0] w;
        forever begin
            bit took;
            took = 0;
            @(negedge clk_i);
            if (!reset_i) begin
                check("stream_v_o", stream_v_o, exp_q.size() != 0);
                if (stream_v_o && stream_ready_i && exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("stream_data_o", stream_data_o, w);
                    last_word = stream_data_o;
                    took = 1;
                end
            end
            @(posedge clk_i);
            if (took) exp_words = (exp_words + 1) % (1 << C);
        end
    end

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic cycle(input bit v, input logic [7:0] b, output bit acc);
        bit           deq;
        int           occ;
        bit           exp_rdy;
        logic [W-1:0] word;
        byte_v_i = v;
        byte_i   = b;
        @(negedge clk_i);
        #1;
        deq     = stream_v_o & stream_ready_i;
        occ     = exp_q.size() + int'(deq);
        exp_rdy = !(pend_q.size() == B - 1 && occ == 2);
        check("byte_ready_o", byte_ready_o, exp_rdy);
        acc = v & byte_ready_o;
        if (acc || pend_q.size() == 0) begin
            idle_cnt = 0;
        end else if (!v) begin
            if (idle_cnt == T - 1) begin
                pend_q.delete();
                idle_cnt = 0;
                exp_drop = 1;
            end else begin
                idle_cnt++;
            end
        end
        if (acc) begin
            pend_q.push_back(b);
            if (pend_q.size() == B) begin
                word = '0;
                for (int i = 0; i < B; i++) word[8*i +: 8] = pend_q[i];
                exp_q.push_back(word);
                words_made++;
                pend_q.delete();
            end
        end
        @(posedge clk_i);
        #1;
        byte_v_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        acc = 0;
        for (int k = 0; k < 50 && !acc; k++) cycle(1'b1, b, acc);
        if (!acc) check("send_byte timeout", acc, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, acc);
    endtask

    task automatic drain();
        bit acc;
        stream_ready_i = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle(1'b0, 8'h00, acc);
        check("drain pending words", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset_i  = 1'b1;
        byte_v_i = 1'b0;
        @(negedge clk_i);
        #1;
        exp_q.delete();
        pend_q.delete();
        idle_cnt   = 0;
        exp_drop   = 0;
        exp_words  = 0;
        words_made = 0;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic status(input string tag);
        check({tag, " words_o"}, words_o, exp_words);
        check({tag, " drop_o"}, drop_o, exp_drop);
    endtask

    initial begin
        bit acc;
        int sent;
        bit saw_bp;
        @(posedge clk_i);
        #1;

        // Reset state
        do_reset();
        check("reset byte_ready_o", byte_ready_o, 1);
        check("reset stream_v_o", stream_v_o, 0);
        check("reset words_o", words_o, 0);
        check("reset drop_o", drop_o, 0);

        // Basic pack and one-cycle latency
        stream_ready_i = 1'b1;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check("basic latency", stream_v_o, 1);
        idle(2);
        check("basic word", last_word, 32'h44332211);
        check("basic words_o", words_o, 1);
        status("basic");

        // Back-pressure fill: two words buffered, third stalls on its last byte
        do_reset();
        stream_ready_i = 1'b0;
        sent   = 0;
        saw_bp = 0;
        for (int k = 0; k < 16 && sent < 12; k++) begin
            cycle(1'b1, 8'(sent), acc);
            if (acc) sent++;
            else saw_bp = 1;
        end
        check("bp stall point", sent, 11);
        check("bp ready dropped", saw_bp, 1);
        stream_ready_i = 1'b1;
        for (int k = sent; k < 12; k++) send_byte(8'(k));
        drain();
        check("bp last word", last_word, 32'h0B0A0908);
        check("bp words_o", words_o, 3);
        status("bp");

        // Timeout drop
        do_reset();
        stream_ready_i = 1'b1;
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(15);
        check("no early drop", drop_o, 0);
        idle(1);
        check("timeout drop_o", drop_o, 1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        drain();
        check("after drop word", last_word, 32'h04030201);
        status("timeout");

        // Byte on the expiry cycle beats the drop
        do_reset();
        stream_ready_i = 1'b1;
        send_byte(8'h10);
        send_byte(8'h20);
        idle(15);
        send_byte(8'h30);
        send_byte(8'h40);
        drain();
        check("race drop_o", drop_o, 0);
        check("race word", last_word, 32'h40302010);
        status("race");

        // Reset with one word buffered and three bytes pending
        do_reset();
        stream_ready_i = 1'b0;
        for (int k = 1; k <= 7; k++) send_byte(8'(k));
        do_reset();
        check("midreset stream_v_o", stream_v_o, 0);
        check("midreset words_o", words_o, 0);
        check("midreset drop_o", drop_o, 0);
        stream_ready_i = 1'b1;
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        drain();
        check("midreset word", last_word, 32'hEFBEADDE);
        status("midreset");

        // Randomized traffic through a 4-bit counter wrap
        do_reset();
        for (int k = 0; k < 3000 && words_made < 17; k++) begin
            stream_ready_i = 1'($urandom_range(0, 1));
            cycle($urandom_range(0, 3) != 0, 8'($urandom), acc);
        end
        check("random words generated", words_made, 17);
        drain();
        check("wrap words_o", words_o, 1);
        status("wrap");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
